// File: rtl/ace_snoop_collector.sv
// ace_snoop_collector
// Buffers ACE snoop requests (AC) from the interconnect, forwards them one at a
// time to the data cache snoop port, collects the cache response (CR) and any
// data beats (CD), and hands one assembled result per request back upstream.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   ac_*                    snoop request from interconnect (valid/ready, addr, snoop, prot)
//   snp_ac_*                request forwarded to cache (valid/ready, addr, snoop, prot)
//   snp_cr_*                cache snoop response (valid/ready, 5-bit CRRESP)
//   snp_cd_*                cache snoop data beats (valid/ready, data, last)
//   res_*                   completed snoop result (valid/ready, addr, resp, has_data, line)
//   err_o                   one-cycle pulse when a CD last flag is misplaced
//   snoop_cnt_o             number of completed snoops, wraps at 2^32
module ace_snoop_collector #(
    parameter int AddrWidth = 64,
    parameter int DataWidth = 64,
    parameter int LineWidth = 128,
    parameter int FifoDepth = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ac_valid_i,
    output logic                 ac_ready_o,
    input  logic [AddrWidth-1:0] ac_addr_i,
    input  logic [3:0]           ac_snoop_i,
    input  logic [2:0]           ac_prot_i,
    output logic                 snp_ac_valid_o,
    input  logic                 snp_ac_ready_i,
    output logic [AddrWidth-1:0] snp_ac_addr_o,
    output logic [3:0]           snp_ac_snoop_o,
    output logic [2:0]           snp_ac_prot_o,
    input  logic                 snp_cr_valid_i,
    output logic                 snp_cr_ready_o,
    input  logic [4:0]           snp_cr_resp_i,
    input  logic                 snp_cd_valid_i,
    output logic                 snp_cd_ready_o,
    input  logic [DataWidth-1:0] snp_cd_data_i,
    input  logic                 snp_cd_last_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic [AddrWidth-1:0] res_addr_o,
    output logic [4:0]           res_resp_o,
    output logic                 res_has_data_o,
    output logic [LineWidth-1:0] res_data_o,
    output logic                 err_o,
    output logic [31:0]          snoop_cnt_o
);

    localparam int NumBeats = LineWidth / DataWidth;
    localparam int BeatW    = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int PtrW     = $clog2(FifoDepth);
    localparam int CntW     = PtrW + 1;
    localparam int ReqW     = AddrWidth + 7;

    typedef enum logic [2:0] {
        IDLE,
        SEND_AC,
        WAIT_CR,
        COLLECT_CD,
        RESULT
    } state_t;

    state_t state;
    state_t state_next;

    logic [ReqW-1:0]      fifo_mem [FifoDepth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [CntW-1:0]      count;
    logic                 push;
    logic                 pop;

    logic [AddrWidth-1:0] req_addr;
    logic [3:0]           req_snoop;
    logic [2:0]           req_prot;
    logic [4:0]           resp;
    logic [LineWidth-1:0] line;
    logic [BeatW-1:0]     beat;
    logic                 err;
    logic [31:0]          snoop_cnt;

    logic                 cr_hs;
    logic                 cd_hs;
    logic                 res_hs;
    logic                 last_beat;

    // Ready looks only at the registered occupancy, so a full FIFO never
    // accepts even if the head is being popped in the same cycle.
    assign ac_ready_o = (count != CntW'(FifoDepth));
    assign push       = ac_valid_i && ac_ready_o;

    assign cr_hs      = (state == WAIT_CR) && snp_cr_valid_i;
    assign cd_hs      = (state == COLLECT_CD) && snp_cd_valid_i;
    assign res_hs     = (state == RESULT) && res_ready_i;
    assign last_beat  = (beat == BeatW'(NumBeats - 1));

    assign snp_ac_addr_o  = req_addr;
    assign snp_ac_snoop_o = req_snoop;
    assign snp_ac_prot_o  = req_prot;
    assign res_addr_o     = req_addr;
    assign res_resp_o     = resp;
    assign res_has_data_o = resp[0];
    assign res_data_o     = line;
    assign err_o          = err;
    assign snoop_cnt_o    = snoop_cnt;

    // Request buffer storage; contents need no reset since count gates reads.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {ac_addr_i, ac_snoop_i, ac_prot_i};
        end
    end

    // Request buffer pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; every output is a function of the
    // state alone, so no valid can drop before its handshake.
    always_comb begin
        state_next     = state;
        pop            = 1'b0;
        snp_ac_valid_o = 1'b0;
        snp_cr_ready_o = 1'b0;
        snp_cd_ready_o = 1'b0;
        res_valid_o    = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = SEND_AC;
                end
            end
            SEND_AC: begin
                snp_ac_valid_o = 1'b1;
                if (snp_ac_ready_i) begin
                    state_next = WAIT_CR;
                end
            end
            WAIT_CR: begin
                snp_cr_ready_o = 1'b1;
                if (snp_cr_valid_i) begin
                    state_next = snp_cr_resp_i[0] ? COLLECT_CD : RESULT;
                end
            end
            COLLECT_CD: begin
                snp_cd_ready_o = 1'b1;
                if (snp_cd_valid_i && last_beat) begin
                    state_next = RESULT;
                end
            end
            RESULT: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: head request, captured response, line assembly, error pulse
    // and completion counter. The beat count alone ends collection; the last
    // flag is only checked, never trusted.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr  <= '0;
            req_snoop <= '0;
            req_prot  <= '0;
            resp      <= '0;
            line      <= '0;
            beat      <= '0;
            err       <= 1'b0;
            snoop_cnt <= '0;
        end else begin
            err <= 1'b0;
            if (pop) begin
                {req_addr, req_snoop, req_prot} <= fifo_mem[rd_ptr];
            end
            if (cr_hs) begin
                resp <= snp_cr_resp_i;
                line <= '0;
                beat <= '0;
            end
            if (cd_hs) begin
                line[beat*DataWidth +: DataWidth] <= snp_cd_data_i;
                beat <= beat + 1'b1;
                err  <= (snp_cd_last_i != last_beat);
            end
            if (res_hs) begin
                snoop_cnt <= snoop_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ace_snoop_collector.sv
// tb_ace_snoop_collector
// Self-checking bench for ace_snoop_collector. Accepted AC requests and the
// responses chosen by the cache model feed an expected-result queue; a
// monitor process pops and compares whenever a result is presented.
module tb_ace_snoop_collector;

    localparam int AddrWidth = 64;
    localparam int DataWidth = 64;
    localparam int LineWidth = 128;
    localparam int FifoDepth = 2;
    localparam int NumBeats  = LineWidth / DataWidth;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 ac_valid_i;
    logic                 ac_ready_o;
    logic [AddrWidth-1:0] ac_addr_i;
    logic [3:0]           ac_snoop_i;
    logic [2:0]           ac_prot_i;
    logic                 snp_ac_valid_o;
    logic                 snp_ac_ready_i;
    logic [AddrWidth-1:0] snp_ac_addr_o;
    logic [3:0]           snp_ac_snoop_o;
    logic [2:0]           snp_ac_prot_o;
    logic                 snp_cr_valid_i;
    logic                 snp_cr_ready_o;
    logic [4:0]           snp_cr_resp_i;
    logic                 snp_cd_valid_i;
    logic                 snp_cd_ready_o;
    logic [DataWidth-1:0] snp_cd_data_i;
    logic                 snp_cd_last_i;
    logic                 res_valid_o;
    logic                 res_ready_i;
    logic [AddrWidth-1:0] res_addr_o;
    logic [4:0]           res_resp_o;
    logic                 res_has_data_o;
    logic [LineWidth-1:0] res_data_o;
    logic                 err_o;
    logic [31:0]          snoop_cnt_o;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [3:0]           snoop;
        logic [2:0]           prot;
    } ac_t;

    typedef struct packed {
        logic [AddrWidth-1:0] addr;
        logic [4:0]           resp;
        logic [LineWidth-1:0] data;
    } res_t;

    ac_t         acQ[$];
    res_t        expQ[$];
    int          total = 0;
    int          bad = 0;
    int          errSeen = 0;
    int          errExp = 0;
    int unsigned cntModel = 0;
    int          holdBudget = 0;
    bit          acBusy = 1'b0;

    ace_snoop_collector #(
        .AddrWidth(AddrWidth),
        .DataWidth(DataWidth),
        .LineWidth(LineWidth),
        .FifoDepth(FifoDepth)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .ac_valid_i(ac_valid_i),
        .ac_ready_o(ac_ready_o),
        .ac_addr_i(ac_addr_i),
        .ac_snoop_i(ac_snoop_i),
        .ac_prot_i(ac_prot_i),
        .snp_ac_valid_o(snp_ac_valid_o),
        .snp_ac_ready_i(snp_ac_ready_i),
        .snp_ac_addr_o(snp_ac_addr_o),
        .snp_ac_snoop_o(snp_ac_snoop_o),
        .snp_ac_prot_o(snp_ac_prot_o),
        .snp_cr_valid_i(snp_cr_valid_i),
        .snp_cr_ready_o(snp_cr_ready_o),
        .snp_cr_resp_i(snp_cr_resp_i),
        .snp_cd_valid_i(snp_cd_valid_i),
        .snp_cd_ready_o(snp_cd_ready_o),
        .snp_cd_data_i(snp_cd_data_i),
        .snp_cd_last_i(snp_cd_last_i),
        .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i),
        .res_addr_o(res_addr_o),
        .res_resp_o(res_resp_o),
        .res_has_data_o(res_has_data_o),
        .res_data_o(res_data_o),
        .err_o(err_o),
        .snoop_cnt_o(snoop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_ac_ready"}, ac_ready_o, 1'b1);
        checkOutput({tag, "_snp_ac_valid"}, snp_ac_valid_o, 1'b0);
        checkOutput({tag, "_cr_ready"}, snp_cr_ready_o, 1'b0);
        checkOutput({tag, "_cd_ready"}, snp_cd_ready_o, 1'b0);
        checkOutput({tag, "_res_valid"}, res_valid_o, 1'b0);
        checkOutput({tag, "_res_addr"}, res_addr_o, '0);
        checkOutput({tag, "_res_resp"}, res_resp_o, '0);
        checkOutput({tag, "_res_has_data"}, res_has_data_o, 1'b0);
        checkOutput({tag, "_res_data"}, res_data_o, '0);
        checkOutput({tag, "_err"}, err_o, 1'b0);
        checkOutput({tag, "_cnt"}, snoop_cnt_o, '0);
    endtask

    function automatic ac_t randomReq();
        ac_t r;
        r.addr  = {$urandom(), $urandom()};
        r.snoop = 4'($urandom_range(0, 15));
        r.prot  = 3'($urandom_range(0, 7));
        return r;
    endfunction

    function automatic logic [LineWidth-1:0] randomLine();
        logic [LineWidth-1:0] l;
        for (int i = 0; i < LineWidth / 32; i++) begin
            l[i*32 +: 32] = $urandom();
        end
        return l;
    endfunction

    // Drive one AC request from a negedge, hold it until accepted, and record
    // it in the acceptance-order queue.
    task automatic applyStimulus(input ac_t req);
        ac_valid_i = 1'b1;
        ac_addr_i  = req.addr;
        ac_snoop_i = req.snoop;
        ac_prot_i  = req.prot;
        while (ac_ready_o !== 1'b1) @(negedge clk_i);
        acQ.push_back(req);
        @(negedge clk_i);
        ac_valid_i = 1'b0;
    endtask

    // Cache model: take one forwarded snoop, answer with resp and, when data
    // is transferred, NumBeats beats of line. Bit i of flips inverts the last
    // flag on beat i. abortAfter >= 0 stops after that many beats (no result
    // is expected then).
    task automatic cacheRespond(input logic [4:0] resp, input logic [LineWidth-1:0] line,
                                input int unsigned flips, input int abortAfter);
        ac_t  expAc;
        res_t expRes;
        int   d;
        while (snp_ac_valid_o !== 1'b1) @(negedge clk_i);
        d = $urandom_range(0, 2);
        repeat (d) begin
            @(negedge clk_i);
            checkOutput("snp_ac_valid_held", snp_ac_valid_o, 1'b1);
        end
        snp_ac_ready_i = 1'b1;
        if (acQ.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL snp_ac_unexpected: got addr %0h expected no request", snp_ac_addr_o);
            expAc = '0;
        end else begin
            expAc = acQ.pop_front();
            checkOutput("snp_ac_addr", snp_ac_addr_o, expAc.addr);
            checkOutput("snp_ac_snoop", snp_ac_snoop_o, expAc.snoop);
            checkOutput("snp_ac_prot", snp_ac_prot_o, expAc.prot);
        end
        @(negedge clk_i);
        snp_ac_ready_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk_i);
        snp_cr_valid_i = 1'b1;
        snp_cr_resp_i  = resp;
        if (abortAfter < 0) begin
            expRes.addr = expAc.addr;
            expRes.resp = resp;
            expRes.data = resp[0] ? line : '0;
            expQ.push_back(expRes);
        end
        while (snp_cr_ready_o !== 1'b1) @(negedge clk_i);
        @(negedge clk_i);
        snp_cr_valid_i = 1'b0;
        if (resp[0]) begin
            for (int i = 0; i < NumBeats; i++) begin
                repeat ($urandom_range(0, 2)) @(negedge clk_i);
                snp_cd_valid_i = 1'b1;
                snp_cd_data_i  = line[i*DataWidth +: DataWidth];
                snp_cd_last_i  = (i == NumBeats - 1) ^ flips[i];
                while (snp_cd_ready_o !== 1'b1) @(negedge clk_i);
                if (flips[i]) errExp++;
                @(negedge clk_i);
                snp_cd_valid_i = 1'b0;
                snp_cd_last_i  = 1'b0;
                if (abortAfter == i + 1) return;
            end
        end
    endtask

    task automatic waitDrain(input string tag);
        int guard = 0;
        while (expQ.size() != 0 && guard < 2000) begin
            @(negedge clk_i);
            guard++;
        end
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_drain: got %0d pending results expected 0", tag, expQ.size());
            expQ.delete();
        end
        repeat (2) @(negedge clk_i);
    endtask

    // Result monitor: randomly backpressures, compares every presented result
    // with the head of the expected queue and pops it on handshake.
    initial begin : monitor
        res_ready_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                res_ready_i = 1'b0;
                continue;
            end
            if (err_o) errSeen++;
            if (res_valid_o && holdBudget > 0) begin
                res_ready_i = 1'b0;
                holdBudget--;
            end else begin
                res_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (res_valid_o) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL res_unexpected: got addr %0h expected no result", res_addr_o);
                end else begin
                    checkOutput("res_addr", res_addr_o, expQ[0].addr);
                    checkOutput("res_resp", res_resp_o, expQ[0].resp);
                    checkOutput("res_has_data", res_has_data_o, expQ[0].resp[0]);
                    checkOutput("res_data", res_data_o, expQ[0].data);
                    if (res_ready_i) begin
                        checkOutput("cnt_at_handshake", snoop_cnt_o, cntModel);
                        void'(expQ.pop_front());
                        cntModel++;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #600000;
        bad++;
        $display("[TB] FAIL watchdog: got no completion expected finish within time limit");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] time limit reached");
    end

    initial begin : main
        ac_t req;
        rst_i          = 1'b1;
        ac_valid_i     = 1'b0;
        ac_addr_i      = '0;
        ac_snoop_i     = '0;
        ac_prot_i      = '0;
        snp_ac_ready_i = 1'b0;
        snp_cr_valid_i = 1'b0;
        snp_cr_resp_i  = '0;
        snp_cd_valid_i = 1'b0;
        snp_cd_data_i  = '0;
        snp_cd_last_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        checkReset("reset");
        rst_i = 1'b0;
        @(negedge clk_i);

        // No-data snoop.
        req = '{addr: 64'h1040, snoop: 4'h0, prot: 3'h0};
        fork
            applyStimulus(req);
            cacheRespond(5'b01000, '0, 0, -1);
        join
        waitDrain("nodata");
        checkOutput("nodata_cnt", snoop_cnt_o, 32'd1);

        // Two-beat data transfer with correct last flag.
        req = randomReq();
        fork
            applyStimulus(req);
            cacheRespond(5'b00101, {64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA}, 0, -1);
        join
        waitDrain("data");
        checkOutput("data_err_count", errSeen, 0);

        // Last flag asserted on beat 0.
        req = randomReq();
        fork
            applyStimulus(req);
            cacheRespond(5'b10001, randomLine(), 1, -1);
        join
        waitDrain("lasterr");
        checkOutput("lasterr_err_count", errSeen, 1);

        // Backpressure: cache stalled, so only FIFO plus head register fill.
        holdBudget = 5;
        acBusy     = 1'b1;
        fork
            begin
                for (int i = 0; i < 4; i++) applyStimulus(randomReq());
                acBusy = 1'b0;
            end
        join_none
        repeat (12) @(negedge clk_i);
        checkOutput("bp_accepted", acQ.size(), FifoDepth + 1);
        checkOutput("bp_ac_ready", ac_ready_o, 1'b0);
        checkOutput("bp_snp_ac_valid", snp_ac_valid_o, 1'b1);
        for (int i = 0; i < 4; i++) cacheRespond(5'b00001, randomLine(), 0, -1);
        waitDrain("bp");
        checkOutput("bp_sender_done", acBusy, 1'b0);

        // Reset while collecting data: everything buffered is dropped.
        req = randomReq();
        fork
            applyStimulus(req);
            cacheRespond(5'b00001, randomLine(), 0, 1);
        join
        checkOutput("pre_reset_cd_ready", snp_cd_ready_o, 1'b1);
        rst_i = 1'b1;
        #1;
        acQ.delete();
        expQ.delete();
        cntModel = 0;
        checkReset("midreset");
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        req = randomReq();
        fork
            applyStimulus(req);
            cacheRespond(5'b01000, '0, 0, -1);
        join
        waitDrain("postreset");
        checkOutput("postreset_cnt", snoop_cnt_o, 32'd1);

        // Randomised traffic.
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk_i);
                    applyStimulus(randomReq());
                end
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [4:0] r;
                    int unsigned f;
                    r = 5'($urandom_range(0, 31));
                    f = ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << NumBeats) - 1) : 0;
                    cacheRespond(r, randomLine(), r[0] ? f : 0, -1);
                end
            end
        join
        waitDrain("random");
        checkOutput("final_err_count", errSeen, errExp);
        checkOutput("final_cnt", snoop_cnt_o, cntModel);
        checkOutput("final_ac_queue", acQ.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
